// File: rtl/ipm2t_hssthp_rst_pkg.sv
// Shared encodings for the HSSTHP reset/retry controller: FSM states and
// the level presented on wtchdg_in when the link is up.
package ipm2t_hssthp_rst_pkg;

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        RST_ASSERT = 3'd1,
        WAIT_LOCK  = 3'd2,
        LOCKED     = 3'd3,
        FAIL       = 3'd4
    } state_t;

    // Watchdog runs with ACTIVE_HIGH=0; a high wtchdg_in stops it once locked.
    localparam logic WTCHDG_IN_DONE = 1'b1;
    localparam logic WTCHDG_IN_IDLE = ~WTCHDG_IN_DONE;

endpackage

// File: rtl/ipm2t_hssthp_rst_lock_filter.sv
// Consecutive-high lock qualifier. With IPM2T_HSSTHP_RETRY_LOCK_SYNC_EN defined,
// lock_in first passes a 2-flop synchronizer; lock_sync exposes the filtered-path lock.
module ipm2t_hssthp_rst_lock_filter #(
    parameter int LOCK_STABLE = 128
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic lock_in,
    output logic stable,
    output logic lock_sync
);

    localparam int CW = $clog2(LOCK_STABLE + 1);
    localparam logic [CW-1:0] CNT_MAX  = CW'(LOCK_STABLE);
    localparam logic [CW-1:0] CNT_LAST = CW'(LOCK_STABLE - 1);

    logic          lock_q;
    logic [CW-1:0] cnt_reg;
    logic [CW-1:0] cnt_next;

`ifdef IPM2T_HSSTHP_RETRY_LOCK_SYNC_EN
    logic [1:0] sync_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_reg <= 2'b00;
        end else begin
            sync_reg <= {sync_reg[0], lock_in};
        end
    end

    assign lock_q = sync_reg[1];
`else
    assign lock_q = lock_in;
`endif

    always_comb begin
        cnt_next = cnt_reg;
        if (clr || !lock_q) begin
            cnt_next = '0;
        end else if (cnt_reg != CNT_MAX) begin
            cnt_next = cnt_reg + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_reg <= '0;
        end else begin
            cnt_reg <= cnt_next;
        end
    end

    // Fires in the cycle that supplies the LOCK_STABLE-th consecutive high sample.
    assign stable    = !clr && lock_q && (cnt_reg == CNT_LAST);
    assign lock_sync = lock_q;

endmodule

// File: rtl/ipm2t_hssthp_rst_retry_ctrl.sv
// HSSTHP reset sequencer with watchdog-driven bounded retry.
// Optional macro IPM2T_HSSTHP_RETRY_LOCK_SYNC_EN adds a lock_in synchronizer.
module ipm2t_hssthp_rst_retry_ctrl
    import ipm2t_hssthp_rst_pkg::*;
#(
    parameter int RST_LEN     = 64,
    parameter int LOCK_STABLE = 128,
    parameter int MAX_RETRY   = 3,
    parameter int RETRY_WIDTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   lock_in,
    input  logic                   wtchdg_rst_n,
    input  logic                   retry_req,
    output logic                   pll_rst,
    output logic                   wtchdg_clr,
    output logic                   wtchdg_in,
    output logic                   done,
    output logic                   fail,
    output logic [RETRY_WIDTH-1:0] retry_cnt
);

    localparam int RCW = $clog2(RST_LEN);
    localparam logic [RCW-1:0]         RST_LAST   = RCW'(RST_LEN - 1);
    localparam logic [RETRY_WIDTH-1:0] RETRY_SAT  = '1;
    localparam logic [RETRY_WIDTH-1:0] RETRY_LAST = RETRY_WIDTH'(MAX_RETRY - 1);

    state_t                 state_reg, state_next;
    logic [RCW-1:0]         rst_cnt_reg, rst_cnt_next;
    logic [RETRY_WIDTH-1:0] retry_cnt_reg, retry_cnt_next;
    logic [RETRY_WIDTH-1:0] retry_inc;
    logic                   wdg_armed_reg, wdg_armed_next;
    logic                   pll_rst_reg, pll_rst_next;
    logic                   clr_reg, clr_next;
    logic                   in_reg, in_next;
    logic                   done_reg, done_next;
    logic                   fail_reg, fail_next;
    logic                   lock_stable;
    logic                   lock_q;
    logic                   timeout;

    ipm2t_hssthp_rst_lock_filter #(
        .LOCK_STABLE (LOCK_STABLE)
    ) u_lock_filter (
        .clk       (clk),
        .rst       (rst),
        .clr       (state_reg != WAIT_LOCK),
        .lock_in   (lock_in),
        .stable    (lock_stable),
        .lock_sync (lock_q)
    );

    // A timeout is only taken once per watchdog pulse: after counting one we
    // wait for wtchdg_rst_n to return high before accepting another.
    assign timeout   = !wtchdg_rst_n && wdg_armed_reg;
    assign retry_inc = (retry_cnt_reg == RETRY_SAT) ? retry_cnt_reg : retry_cnt_reg + 1'b1;

    always_comb begin
        state_next     = state_reg;
        rst_cnt_next   = rst_cnt_reg;
        retry_cnt_next = retry_cnt_reg;
        wdg_armed_next = wtchdg_rst_n ? 1'b1 : wdg_armed_reg;

        case (state_reg)
            IDLE: begin
                state_next   = RST_ASSERT;
                rst_cnt_next = '0;
            end
            RST_ASSERT: begin
                if (rst_cnt_reg == RST_LAST) begin
                    state_next   = WAIT_LOCK;
                    rst_cnt_next = '0;
                end else begin
                    rst_cnt_next = rst_cnt_reg + 1'b1;
                end
            end
            WAIT_LOCK: begin
                if (lock_stable) begin
                    state_next = LOCKED;
                end else if (timeout) begin
                    retry_cnt_next = retry_inc;
                    wdg_armed_next = 1'b0;
                    rst_cnt_next   = '0;
                    state_next     = (retry_cnt_reg == RETRY_LAST) ? FAIL : RST_ASSERT;
                end
            end
            LOCKED: begin
                if (!lock_q) begin
                    state_next     = RST_ASSERT;
                    retry_cnt_next = '0;
                    rst_cnt_next   = '0;
                end
            end
            FAIL: begin
                if (retry_req) begin
                    state_next     = RST_ASSERT;
                    retry_cnt_next = '0;
                    rst_cnt_next   = '0;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        // Outputs are decoded from the next state so they register on entry.
        pll_rst_next = (state_next == IDLE) || (state_next == RST_ASSERT) || (state_next == FAIL);
        clr_next     = pll_rst_next;
        in_next      = (state_next == LOCKED) ? WTCHDG_IN_DONE : WTCHDG_IN_IDLE;
        done_next    = (state_next == LOCKED);
        fail_next    = (state_next == FAIL);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= IDLE;
            rst_cnt_reg   <= '0;
            retry_cnt_reg <= '0;
            wdg_armed_reg <= 1'b1;
            pll_rst_reg   <= 1'b1;
            clr_reg       <= 1'b1;
            in_reg        <= WTCHDG_IN_IDLE;
            done_reg      <= 1'b0;
            fail_reg      <= 1'b0;
        end else begin
            state_reg     <= state_next;
            rst_cnt_reg   <= rst_cnt_next;
            retry_cnt_reg <= retry_cnt_next;
            wdg_armed_reg <= wdg_armed_next;
            pll_rst_reg   <= pll_rst_next;
            clr_reg       <= clr_next;
            in_reg        <= in_next;
            done_reg      <= done_next;
            fail_reg      <= fail_next;
        end
    end

    assign pll_rst    = pll_rst_reg;
    assign wtchdg_clr = clr_reg;
    assign wtchdg_in  = in_reg;
    assign done       = done_reg;
    assign fail       = fail_reg;
    assign retry_cnt  = retry_cnt_reg;

endmodule

// File: tb/tb_ipm2t_hssthp_rst_retry_ctrl.sv
// Scoreboard bench: stimulus queues the expected output vector and the cycle it
// should appear; a negedge monitor pops one entry per observed output change.
module tb_ipm2t_hssthp_rst_retry_ctrl;

    localparam int RST_LEN     = 64;
    localparam int LOCK_STABLE = 128;
`ifdef IPM2T_HSSTHP_RETRY_LOCK_SYNC_EN
    localparam int S = 2;
`else
    localparam int S = 0;
`endif

    typedef struct {
        logic [8:0] vec;
        int         cyc;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       lock_in = 1'b0;
    logic       wtchdg_rst_n = 1'b1;
    logic       retry_req = 1'b0;
    logic       pll_rst, wtchdg_clr, wtchdg_in, done, fail;
    logic [3:0] retry_cnt;

    int   cyc = 0;
    int   n_vec = 0;
    int   n_miss = 0;
    bit   stim_done = 1'b0;
    bit   started = 1'b0;
    logic [8:0] last_vec;
    logic [8:0] cur_vec;
    exp_t q[$];
    exp_t e;

    ipm2t_hssthp_rst_retry_ctrl #(
        .RST_LEN     (RST_LEN),
        .LOCK_STABLE (LOCK_STABLE),
        .MAX_RETRY   (3),
        .RETRY_WIDTH (4)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .lock_in      (lock_in),
        .wtchdg_rst_n (wtchdg_rst_n),
        .retry_req    (retry_req),
        .pll_rst      (pll_rst),
        .wtchdg_clr   (wtchdg_clr),
        .wtchdg_in    (wtchdg_in),
        .done         (done),
        .fail         (fail),
        .retry_cnt    (retry_cnt)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Vector layout: {pll_rst, wtchdg_clr, wtchdg_in, done, fail, retry_cnt[3:0]}
    function automatic logic [8:0] v_rst(input logic [3:0] r);
        return {1'b1, 1'b1, 1'b0, 1'b0, 1'b0, r};
    endfunction
    function automatic logic [8:0] v_wait(input logic [3:0] r);
        return {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, r};
    endfunction
    function automatic logic [8:0] v_lock(input logic [3:0] r);
        return {1'b0, 1'b0, 1'b1, 1'b1, 1'b0, r};
    endfunction
    function automatic logic [8:0] v_fail(input logic [3:0] r);
        return {1'b1, 1'b1, 1'b0, 1'b0, 1'b1, r};
    endfunction

    function automatic void push(input logic [8:0] v, input int c);
        exp_t x;
        x.vec = v;
        x.cyc = c;
        q.push_back(x);
    endfunction

    // Returns 2 time units after posedge number t, when inputs are safe to drive.
    task automatic at_cyc(input int t);
        while (cyc < t) begin
            @(posedge clk);
            #2;
        end
    endtask

    // Monitor: one transaction per change of the output vector.
    always @(negedge clk) begin
        cur_vec = {pll_rst, wtchdg_clr, wtchdg_in, done, fail, retry_cnt};
        if (!started || cur_vec !== last_vec) begin
            started  = 1'b1;
            last_vec = cur_vec;
            n_vec++;
            if (q.size() == 0) begin
                n_miss++;
                $display("FAIL unexpected_change cyc %0d got %b required no change", cyc, cur_vec);
            end else begin
                e = q.pop_front();
                if (cur_vec !== e.vec || cyc != e.cyc) begin
                    n_miss++;
                    $display("FAIL out_vec got %b at cyc %0d required %b at cyc %0d",
                             cur_vec, cyc, e.vec, e.cyc);
                end else begin
                    $display("vec %0d cyc %0d outputs %b ok", n_vec, cyc, cur_vec);
                end
            end
        end
        if (stim_done) begin
            while (q.size() > 0) begin
                e = q.pop_front();
                n_vec++;
                n_miss++;
                $display("FAIL missing_change got none required %b at cyc %0d", e.vec, e.cyc);
            end
            $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
            $finish;
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout got cyc %0d required finish before 20000 cycles", cyc);
        $fatal(1, "bench timeout");
    end

    initial begin
        int w, l, c, r, s, f, a;

        // Reset state, then nominal bring-up.
        push(v_rst(4'd0), 1);
        at_cyc(3);
        rst = 1'b0;
        w = 3 + 1 + RST_LEN;
        l = w + LOCK_STABLE;
        push(v_wait(4'd0), w);
        push(v_lock(4'd0), l);
        at_cyc(13);
        lock_in = 1'b1;

        // retry_req and watchdog pulses are ignored while LOCKED.
        at_cyc(l + 4);
        retry_req = 1'b1;
        at_cyc(l + 5);
        retry_req = 1'b0;
        at_cyc(l + 8);
        wtchdg_rst_n = 1'b0;
        at_cyc(l + 18);
        wtchdg_rst_n = 1'b1;

        // Single-cycle lock drop while LOCKED restarts the reset sequence.
        c = l + 24;
        at_cyc(c);
        lock_in = 1'b0;
        push(v_rst(4'd0), c + 1 + S);
        at_cyc(c + 1);
        lock_in = 1'b1;
        w = c + 1 + S + RST_LEN;
        push(v_wait(4'd0), w);
        push(v_lock(4'd0), w + LOCK_STABLE);

        // Glitch rejection inside WAIT_LOCK.
        c = w + LOCK_STABLE + 10;
        at_cyc(c);
        lock_in = 1'b0;
        push(v_rst(4'd0), c + 1 + S);
        w = c + 1 + S + RST_LEN;
        push(v_wait(4'd0), w);
        push(v_lock(4'd0), w + 234 + S);
        at_cyc(w + 5);
        lock_in = 1'b1;
        at_cyc(w + 105);
        lock_in = 1'b0;
        at_cyc(w + 106);
        lock_in = 1'b1;

        // Lock qualification and timeout in the same cycle: lock wins.
        c = w + 234 + S + 10;
        at_cyc(c);
        lock_in = 1'b0;
        push(v_rst(4'd0), c + 1 + S);
        w = c + 1 + S + RST_LEN;
        push(v_wait(4'd0), w);
        at_cyc(w + 5);
        lock_in = 1'b1;
        r = w + 6 + S;
        push(v_lock(4'd0), r + LOCK_STABLE - 1);
        at_cyc(r + LOCK_STABLE - 2);
        wtchdg_rst_n = 1'b0;
        at_cyc(r + LOCK_STABLE - 1);
        wtchdg_rst_n = 1'b1;

        // Three long watchdog pulses with no lock: 1, 2, then FAIL at 3.
        c = r + LOCK_STABLE + 10;
        at_cyc(c);
        lock_in = 1'b0;
        push(v_rst(4'd0), c + 1 + S);
        w = c + 1 + S + RST_LEN;
        push(v_wait(4'd0), w);
        for (int p = 0; p < 3; p++) begin
            s = w + 10 + p * 520;
            if (p < 2) begin
                push(v_rst(4'(p + 1)), s + 1);
                push(v_wait(4'(p + 1)), s + 1 + RST_LEN);
            end else begin
                push(v_fail(4'd3), s + 1);
            end
            at_cyc(s);
            wtchdg_rst_n = 1'b0;
            at_cyc(s + 512);
            wtchdg_rst_n = 1'b1;
        end

        // FAIL ignores lock and watchdog; retry_req recovers.
        f = w + 10 + 2 * 520 + 530;
        at_cyc(f - 20);
        lock_in = 1'b1;
        at_cyc(f - 15);
        wtchdg_rst_n = 1'b0;
        at_cyc(f - 10);
        wtchdg_rst_n = 1'b1;
        push(v_rst(4'd0), f + 1);
        push(v_wait(4'd0), f + 1 + RST_LEN);
        push(v_lock(4'd0), f + 1 + RST_LEN + LOCK_STABLE);
        at_cyc(f);
        retry_req = 1'b1;
        at_cyc(f + 1);
        retry_req = 1'b0;

        // Asynchronous reset while LOCKED, then a fresh bring-up.
        a = f + 1 + RST_LEN + LOCK_STABLE + 10;
        push(v_rst(4'd0), a);
        at_cyc(a);
        rst = 1'b1;
        at_cyc(a + 2);
        rst = 1'b0;
        push(v_wait(4'd0), a + 3 + RST_LEN);
        push(v_lock(4'd0), a + 3 + RST_LEN + LOCK_STABLE);
        at_cyc(a + 3 + RST_LEN + LOCK_STABLE + 20);
        stim_done = 1'b1;
    end

endmodule
